// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with glitch-free start/stop and divisor updates.
// Optional period counter: define CLK_DIV_CTRL_PCNT_EN.
module clk_div_ctrl #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] div_val,
  input  logic         div_valid,
  output logic         div_ready,
  output logic         clk_out,
  output logic         tick,
  output logic         busy,
  output logic         err
`ifdef CLK_DIV_CTRL_PCNT_EN
  ,
  input  logic         pcnt_clr,
  output logic [15:0]  period_cnt
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  logic [0:0]   state_q, state_d;
  logic [W-1:0] cur_q, cur_d;
  logic [W-1:0] ph_q, ph_d;
  logic [W-1:0] pdiv_q, pdiv_d;
  logic         pend_q, pend_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;
  logic         err_q, err_d;
  logic [W-1:0] hi;
  logic         acc;

  assign hi  = cur_q - (cur_q >> 1);
  assign acc = div_valid && !pend_q;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ph_d    = ph_q;
    pdiv_d  = pdiv_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    err_d   = 1'b0;
    if (acc) begin
      if (div_val >= TWO) begin
        pend_d = 1'b1;
        pdiv_d = div_val;
      end else begin
        err_d = 1'b1;
      end
    end
    unique case (state_q)
      IDLE: begin
        ph_d  = '0;
        clk_d = 1'b0;
        if (pend_q) begin
          cur_d  = pdiv_q;
          pend_d = 1'b0;
        end
        if (enable) begin
          state_d = RUN;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end
      RUN: begin
        if (ph_q == cur_q - ONE) begin
          // a pending divisor is only applied at a period boundary
          if (pend_q) begin
            cur_d  = pdiv_q;
            pend_d = 1'b0;
          end
          ph_d = '0;
          if (!enable) begin
            state_d = IDLE;
            clk_d   = 1'b0;
          end else begin
            clk_d  = 1'b1;
            tick_d = 1'b1;
          end
        end else begin
          ph_d  = ph_q + ONE;
          clk_d = (ph_d < hi);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= W'(DEFAULT_DIV);
      ph_q    <= '0;
      pdiv_q  <= '0;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ph_q    <= ph_d;
      pdiv_q  <= pdiv_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign div_ready = !pend_q;
  assign clk_out   = clk_q;
  assign tick      = tick_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

`ifdef CLK_DIV_CTRL_PCNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_in) begin
    if (reset || pcnt_clr) begin
      cnt_q <= '0;
    end else if (tick_q && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign period_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: vector table through a scoreboard queue,
// then hand-written multi-cycle sequences.
module tb_clk_div_ctrl;

  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] div_val;
  logic         div_valid;
  logic         div_ready;
  logic         clk_out;
  logic         tick;
  logic         busy;
  logic         err;
`ifdef CLK_DIV_CTRL_PCNT_EN
  logic         pcnt_clr;
  logic [15:0]  period_cnt;
`endif

  clk_div_ctrl #(.W(W), .DEFAULT_DIV(3)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .enable    (enable),
    .div_val   (div_val),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .err       (err)
`ifdef CLK_DIV_CTRL_PCNT_EN
    ,
    .pcnt_clr  (pcnt_clr),
    .period_cnt(period_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic         rst;
    logic         en;
    logic         dv;
    logic [W-1:0] val;
    logic [4:0]   exp;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] sb[$];
  int         passed = 0;
  int         total  = 0;

  function automatic vec_t mk(logic r, logic e, logic d, int v,
                              logic c, logic t, logic b,
                              logic y, logic x);
    vec_t o;
    o.rst = r;
    o.en  = e;
    o.dv  = d;
    o.val = W'(v);
    o.exp = {c, t, b, y, x};
    return o;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 1000);
  endtask

  initial begin
    int n;
    int hc;
    logic [4:0] e;
    logic [4:0] a;
    reset = 1'b1;
    enable = 1'b0;
    div_val = '0;
    div_valid = 1'b0;
`ifdef CLK_DIV_CTRL_PCNT_EN
    pcnt_clr = 1'b0;
`endif
    // rst en dv val | clk tick busy rdy err
    vecs.push_back(mk(1,0,0,0,  0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,  0,0,0,1,0));
    vecs.push_back(mk(0,1,0,0,  1,1,1,1,0));
    vecs.push_back(mk(0,1,0,0,  1,0,1,1,0));
    vecs.push_back(mk(0,1,0,0,  0,0,1,1,0));
    vecs.push_back(mk(0,1,0,0,  1,1,1,1,0));
    vecs.push_back(mk(0,1,1,4,  1,0,1,0,0));
    vecs.push_back(mk(0,1,0,0,  0,0,1,0,0));
    vecs.push_back(mk(0,1,0,0,  1,1,1,1,0));
    vecs.push_back(mk(0,1,0,0,  1,0,1,1,0));
    vecs.push_back(mk(0,1,0,0,  0,0,1,1,0));
    vecs.push_back(mk(0,1,0,0,  0,0,1,1,0));
    vecs.push_back(mk(0,1,0,0,  1,1,1,1,0));
    vecs.push_back(mk(0,1,1,1,  1,0,1,1,1));
    vecs.push_back(mk(0,1,1,0,  0,0,1,1,1));
    vecs.push_back(mk(0,1,0,0,  0,0,1,1,0));
    vecs.push_back(mk(0,1,0,0,  1,1,1,1,0));
    vecs.push_back(mk(0,1,1,5,  1,0,1,0,0));
    vecs.push_back(mk(0,1,0,0,  0,0,1,0,0));
    vecs.push_back(mk(0,1,0,0,  0,0,1,0,0));
    vecs.push_back(mk(0,1,0,0,  1,1,1,1,0));
    vecs.push_back(mk(0,1,0,0,  1,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,  1,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,  0,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,  0,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,  0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,  0,0,0,1,0));
    vecs.push_back(mk(0,1,0,0,  1,1,1,1,0));
    vecs.push_back(mk(0,1,0,0,  1,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,  1,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,  0,0,1,1,0));
    vecs.push_back(mk(0,1,0,0,  0,0,1,1,0));
    vecs.push_back(mk(0,1,0,0,  1,1,1,1,0));
    vecs.push_back(mk(0,1,1,7,  1,0,1,0,0));
    vecs.push_back(mk(0,1,0,0,  1,0,1,0,0));
    vecs.push_back(mk(1,1,0,0,  0,0,0,1,0));
    vecs.push_back(mk(0,1,0,0,  1,1,1,1,0));
    vecs.push_back(mk(0,1,0,0,  1,0,1,1,0));
    vecs.push_back(mk(0,1,0,0,  0,0,1,1,0));
    vecs.push_back(mk(0,1,0,0,  1,1,1,1,0));
    vecs.push_back(mk(0,0,0,0,  1,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,  0,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,  0,0,0,1,0));
    vecs.push_back(mk(0,0,1,2,  0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,  0,0,0,1,0));
    vecs.push_back(mk(0,1,0,0,  1,1,1,1,0));
    vecs.push_back(mk(0,1,0,0,  0,0,1,1,0));
    vecs.push_back(mk(0,1,0,0,  1,1,1,1,0));
    vecs.push_back(mk(0,0,0,0,  0,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,  0,0,0,1,0));
    vecs.push_back(mk(0,0,1,255,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,  1,1,1,1,0));
    vecs.push_back(mk(0,1,0,0,  1,0,1,1,0));

    step();
    for (int i = 0; i < vecs.size(); i++) begin
      reset     = vecs[i].rst;
      enable    = vecs[i].en;
      div_valid = vecs[i].dv;
      div_val   = vecs[i].val;
      sb.push_back(vecs[i].exp);
      step();
      e = sb.pop_front();
      a = {clk_out, tick, busy, div_ready, err};
      total++;
      if (a === e) passed++;
      else $display("FAIL vec%0d {clk,tick,busy,rdy,err}: got %b expected %b",
                    i, a, e);
    end
    div_valid = 1'b0;

    // divisor accepted exactly on a boundary waits one full period
    reset = 1'b1;
    enable = 1'b0;
    step();
    reset = 1'b0;
    enable = 1'b1;
    step();
    step();
    step();
    chk("ph2_clk", int'(clk_out), 0);
    div_valid = 1'b1;
    div_val = 8'd4;
    step();
    div_valid = 1'b0;
    chk("bnd_acc_tick", int'(tick), 1);
    chk("bnd_acc_rdy", int'(div_ready), 0);
    wait_tick(n);
    chk("bnd_old_period", n, 3);
    chk("bnd_apply_rdy", int'(div_ready), 1);
    wait_tick(n);
    chk("bnd_new_period", n, 4);

    // max divisor: period 255, high for 128 cycles
    div_valid = 1'b1;
    div_val = 8'd255;
    step();
    div_valid = 1'b0;
    wait_tick(n);
    hc = 1;
    n = 0;
    do begin
      step();
      n++;
      if (clk_out && !tick) hc++;
    end while (!tick && n < 1000);
    chk("max_period", n, 255);
    chk("max_high", hc, 128);
    chk("max_busy", int'(busy), 1);

`ifdef CLK_DIV_CTRL_PCNT_EN
    reset = 1'b1;
    enable = 1'b0;
    step();
    chk("pcnt_reset", int'(period_cnt), 0);
    reset = 1'b0;
    enable = 1'b1;
    n = 0;
    hc = 0;
    while (n < 10 && hc < 200) begin
      step();
      hc++;
      if (tick) n++;
    end
    step();
    chk("pcnt_10", int'(period_cnt), 10);
    wait_tick(n);
    pcnt_clr = 1'b1;
    step();
    pcnt_clr = 1'b0;
    chk("pcnt_clr_tick", int'(period_cnt), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
